// File: rtl/mem_arbiter_if.sv
// Request/grant bundle between the two memory requesters, the arbiter and the memory.
// The slave view belongs to the arbiter; the master view is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  req_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic                  gnt_a;
  logic                  rvalid_a;
  logic [DATA_WIDTH-1:0] rdata_a;

  logic                  req_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  gnt_b;
  logic                  rvalid_b;
  logic [DATA_WIDTH-1:0] rdata_b;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_out;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_out,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output mem_we, mem_addr, mem_data
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_out,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between two requesters.
// A port that keeps requesting loses ownership after MAX_BURST grants if the other port waits.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t                state_r, state_s;
  logic [3:0]            burst_cnt_r, burst_cnt_s;
  logic                  last_b_r, last_b_s;
  logic                  grant_a_s, grant_b_s;
  logic                  issue_a_s, issue_b_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s, addr_hold_r;
  logic [DATA_WIDTH-1:0] mem_data_s, data_hold_r;
  logic                  rvalid_a_r, rvalid_b_r;

  // Ownership state, burst length and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      burst_cnt_r <= 4'd0;
      last_b_r    <= 1'b1;
    end else begin
      state_r     <= state_s;
      burst_cnt_r <= burst_cnt_s;
      last_b_r    <= last_b_s;
    end
  end

  // Grant decision: the owner keeps the memory until its burst is spent or it lets go
  always_comb begin
    state_s     = state_r;
    burst_cnt_s = burst_cnt_r;
    last_b_s    = last_b_r;
    grant_a_s   = 1'b0;
    grant_b_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_b_r)) begin
          grant_a_s   = 1'b1;
          state_s     = OWN_A;
          burst_cnt_s = 4'd1;
        end else if (bus.req_b) begin
          grant_b_s   = 1'b1;
          state_s     = OWN_B;
          burst_cnt_s = 4'd1;
        end else begin
          state_s     = IDLE;
        end
      end
      OWN_A: begin
        if (bus.req_a && (!bus.req_b || (burst_cnt_r < BURST_MAX))) begin
          grant_a_s   = 1'b1;
          burst_cnt_s = (burst_cnt_r < BURST_MAX) ? (burst_cnt_r + 4'd1) : burst_cnt_r;
        end else if (bus.req_b) begin
          grant_b_s   = 1'b1;
          state_s     = OWN_B;
          burst_cnt_s = 4'd1;
          last_b_s    = 1'b0;
        end else begin
          state_s     = IDLE;
          burst_cnt_s = 4'd0;
          last_b_s    = 1'b0;
        end
      end
      OWN_B: begin
        if (bus.req_b && (!bus.req_a || (burst_cnt_r < BURST_MAX))) begin
          grant_b_s   = 1'b1;
          burst_cnt_s = (burst_cnt_r < BURST_MAX) ? (burst_cnt_r + 4'd1) : burst_cnt_r;
        end else if (bus.req_a) begin
          grant_a_s   = 1'b1;
          state_s     = OWN_A;
          burst_cnt_s = 4'd1;
          last_b_s    = 1'b1;
        end else begin
          state_s     = IDLE;
          burst_cnt_s = 4'd0;
          last_b_s    = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        burst_cnt_s = 4'd0;
      end
    endcase
  end

  // Grants are gated by reset so nothing reaches the memory while rst_n is low
  assign issue_a_s = grant_a_s & rst_n;
  assign issue_b_s = grant_b_s & rst_n;

  // Memory port mux; between accesses the last issued address/data stay on the bus
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = addr_hold_r;
    mem_data_s = data_hold_r;
    if (issue_a_s) begin
      mem_we_s   = bus.we_a;
      mem_addr_s = bus.addr_a;
      mem_data_s = bus.wdata_a;
    end else if (issue_b_s) begin
      mem_we_s   = bus.we_b;
      mem_addr_s = bus.addr_b;
      mem_data_s = bus.wdata_b;
    end else begin
      mem_we_s   = 1'b0;
    end
  end

  // Hold registers for the idle-bus address/data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_r <= '0;
      data_hold_r <= '0;
    end else if (issue_a_s || issue_b_s) begin
      addr_hold_r <= mem_addr_s;
      data_hold_r <= mem_data_s;
    end else begin
      addr_hold_r <= addr_hold_r;
      data_hold_r <= data_hold_r;
    end
  end

  // Read-return tracking: memory output lands one cycle after the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
    end else begin
      rvalid_a_r <= issue_a_s & ~bus.we_a;
      rvalid_b_r <= issue_b_s & ~bus.we_b;
    end
  end

  assign bus.gnt_a    = issue_a_s;
  assign bus.gnt_b    = issue_b_s;
  assign bus.mem_we   = mem_we_s;
  assign bus.mem_addr = mem_addr_s;
  assign bus.mem_data = mem_data_s;
  assign bus.rvalid_a = rvalid_a_r;
  assign bus.rvalid_b = rvalid_b_r;
  assign bus.rdata_a  = bus.mem_out;
  assign bus.rdata_b  = bus.mem_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous memory model plus a grant-history reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Synchronous single-port memory: write and registered read on the same edge
  logic [DW-1:0] ram [64] = '{5: 16'h1234, default: 16'h0000};
  logic [DW-1:0] mem_q = 16'h0000;
  assign bus.mem_out = mem_q;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    mem_q <= ram[bus.mem_addr];
  end

  // Reference model state: who was granted last cycle, streak length, previous owner
  int            m_prev = 0;   // 0 none, 1 A, 2 B
  int            m_run  = 0;   // consecutive grants to m_prev (unbounded)
  int            m_last = 2;   // owner before the most recent hand-over
  logic [AW-1:0] m_addr = '0;
  logic          m_rv_a = 1'b0, m_rv_b = 1'b0;
  logic [DW-1:0] m_rd_a = '0, m_rd_b = '0;
  logic [DW-1:0] shadow [64] = '{5: 16'h1234, default: 16'h0000};
  int            exp_g;
  logic          exp_we;
  logic [AW-1:0] exp_addr;

  function automatic int pick(input int prev, input int run, input int lastp,
                              input logic ra, input logic rb);
    int res;
    res = 0;
    if (prev == 1)      res = (ra && (!rb || run < MB)) ? 1 : (rb ? 2 : 0);
    else if (prev == 2) res = (rb && (!ra || run < MB)) ? 2 : (ra ? 1 : 0);
    else if (ra && rb)  res = (lastp == 1) ? 2 : 1;
    else                res = ra ? 1 : (rb ? 2 : 0);
    return res;
  endfunction

  always_comb begin
    exp_g = 0;
    if (rst_n === 1'b1) exp_g = pick(m_prev, m_run, m_last, bus.req_a, bus.req_b);
    exp_we   = (exp_g == 1) ? bus.we_a : ((exp_g == 2) ? bus.we_b : 1'b0);
    exp_addr = (exp_g == 1) ? bus.addr_a : ((exp_g == 2) ? bus.addr_b : m_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 0; m_run <= 0; m_last <= 2; m_addr <= '0;
      m_rv_a <= 1'b0; m_rv_b <= 1'b0;
    end else begin
      if (m_prev != 0 && exp_g != m_prev) m_last <= m_prev;
      m_run  <= (exp_g == 0) ? 0 : ((exp_g == m_prev) ? m_run + 1 : 1);
      m_prev <= exp_g;
      m_rv_a <= (exp_g == 1) && !bus.we_a;
      m_rv_b <= (exp_g == 2) && !bus.we_b;
      if (exp_g == 1) begin
        m_rd_a <= shadow[bus.addr_a];
        m_addr <= bus.addr_a;
        if (bus.we_a) shadow[bus.addr_a] <= bus.wdata_a;
      end else if (exp_g == 2) begin
        m_rd_b <= shadow[bus.addr_b];
        m_addr <= bus.addr_b;
        if (bus.we_b) shadow[bus.addr_b] <= bus.wdata_b;
      end
    end
  end

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'd0; bus.wdata_a = 16'hCAFE;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 6'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.gnt_a, bus.gnt_b, bus.mem_we, bus.rvalid_a, bus.rvalid_b} !== 5'b00000) begin
        n_errors++;
        $display("FAIL reset_outputs: gnt_a,gnt_b,mem_we,rvalid_a,rvalid_b=%b expected 00000",
                 {bus.gnt_a, bus.gnt_b, bus.mem_we, bus.rvalid_a, bus.rvalid_b});
      end
      n_checks++;
      if (bus.mem_addr !== 6'd0) begin
        n_errors++;
        $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr);
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first_grant: gnt_a=%b gnt_b=%b expected 1 0", bus.gnt_a, bus.gnt_b);
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++;
    if (bus.rvalid_a !== 1'b0) begin
      n_errors++;
      $display("FAIL write_no_rvalid: rvalid_a=%b expected 0", bus.rvalid_a);
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 6'd5; #1;
    n_checks++;
    if (bus.gnt_a !== 1'b1) begin
      n_errors++;
      $display("FAIL read_gnt: gnt_a=%b expected 1", bus.gnt_a);
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 16'h1234) begin
      n_errors++;
      $display("FAIL read_data: rvalid_a=%b rdata_a=%0h expected 1 1234", bus.rvalid_a, bus.rdata_a);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.rvalid_a !== 1'b0) begin
      n_errors++;
      $display("FAIL read_single_cycle: rvalid_a=%b expected 0", bus.rvalid_a);
    end
  endtask

  task automatic test_raw();
    @(negedge clk);
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 6'd10; bus.wdata_b = 16'hBEEF; #1;
    n_checks++;
    if (bus.gnt_b !== 1'b1 || bus.mem_we !== 1'b1) begin
      n_errors++;
      $display("FAIL raw_write: gnt_b=%b mem_we=%b expected 1 1", bus.gnt_b, bus.mem_we);
    end
    @(negedge clk);
    idle_inputs();
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 6'd10; #1;
    n_checks++;
    if (bus.gnt_a !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL raw_read_gnt: gnt_a=%b mem_we=%b expected 1 0", bus.gnt_a, bus.mem_we);
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL raw_data: rvalid_a=%b rdata_a=%0h expected 1 beef", bus.rvalid_a, bus.rdata_a);
    end
  endtask

  task automatic test_burst();
    int pat[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 6'd5;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 6'd10;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (bus.gnt_a !== (pat[i] == 1) || bus.gnt_b !== (pat[i] == 2) || exp_g != pat[i]) begin
        n_errors++;
        $display("FAIL burst_seq[%0d]: gnt_a=%b gnt_b=%b model=%0d expected owner %0d",
                 i, bus.gnt_a, bus.gnt_b, exp_g, pat[i]);
      end
      if (bus.rvalid_a === 1'b1) begin
        n_checks++;
        if (bus.rdata_a !== m_rd_a) begin
          n_errors++;
          $display("FAIL burst_rdata_a: got %0h expected %0h", bus.rdata_a, m_rd_a);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_drop();
    int pat[7] = '{1, 1, 2, 2, 2, 2, 1};
    logic ra[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic rb[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      bus.req_a = ra[i]; bus.we_a = 1'b0; bus.addr_a = 6'(i);
      bus.req_b = rb[i]; bus.we_b = 1'b0; bus.addr_b = 6'(i + 8);
      #1;
      n_checks++;
      if (bus.gnt_a !== (pat[i] == 1) || bus.gnt_b !== (pat[i] == 2)) begin
        n_errors++;
        $display("FAIL drop_seq[%0d]: gnt_a=%b gnt_b=%b expected owner %0d",
                 i, bus.gnt_a, bus.gnt_b, pat[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 6'd3; #1;
    n_checks++;
    if (bus.gnt_b !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_gnt_b: gnt_b=%b expected 1", bus.gnt_b);
    end
    #1 rst_n = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 6'd4; #1;
    n_checks++;
    if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_forced: gnt_a=%b gnt_b=%b mem_we=%b expected 0 0 0",
               bus.gnt_a, bus.gnt_b, bus.mem_we);
    end
    #1 rst_n = 1'b1; #1;
    n_checks++;
    if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_after_release: gnt_a=%b gnt_b=%b expected 1 0", bus.gnt_a, bus.gnt_b);
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++;
    if (bus.rvalid_b !== 1'b0 || bus.rvalid_a !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_rvalid: rvalid_a=%b rvalid_b=%b expected 1 0", bus.rvalid_a, bus.rvalid_b);
    end
  endtask

  task automatic test_random();
    logic pend_a = 1'b0, pend_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_prev == 1) pend_a = 1'b0;
      if (m_prev == 2) pend_b = 1'b0;
      if (!pend_a && $urandom_range(0, 99) < 60) begin
        pend_a = 1'b1; bus.we_a = 1'($urandom_range(0, 1));
        bus.addr_a = 6'($urandom_range(0, 7)); bus.wdata_a = 16'($urandom);
      end
      if (!pend_b && $urandom_range(0, 99) < 60) begin
        pend_b = 1'b1; bus.we_b = 1'($urandom_range(0, 1));
        bus.addr_b = 6'($urandom_range(0, 7)); bus.wdata_b = 16'($urandom);
      end
      bus.req_a = pend_a; bus.req_b = pend_b;
      #1;
      n_checks++;
      if (bus.gnt_a !== (exp_g == 1) || bus.gnt_b !== (exp_g == 2)) begin
        n_errors++;
        $display("FAIL rnd_gnt@%0d: gnt_a=%b gnt_b=%b expected owner %0d", c, bus.gnt_a, bus.gnt_b, exp_g);
      end
      n_checks++;
      if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr) begin
        n_errors++;
        $display("FAIL rnd_mem@%0d: mem_we=%b mem_addr=%0h expected %b %0h",
                 c, bus.mem_we, bus.mem_addr, exp_we, exp_addr);
      end
      n_checks++;
      if (bus.rvalid_a !== m_rv_a || bus.rvalid_b !== m_rv_b) begin
        n_errors++;
        $display("FAIL rnd_rvalid@%0d: rvalid_a=%b rvalid_b=%b expected %b %b",
                 c, bus.rvalid_a, bus.rvalid_b, m_rv_a, m_rv_b);
      end
      if (m_rv_a) begin
        n_checks++;
        if (bus.rdata_a !== m_rd_a) begin
          n_errors++;
          $display("FAIL rnd_rdata_a@%0d: got %0h expected %0h", c, bus.rdata_a, m_rd_a);
        end
      end
      if (m_rv_b) begin
        n_checks++;
        if (bus.rdata_b !== m_rd_b) begin
          n_errors++;
          $display("FAIL rnd_rdata_b@%0d: got %0h expected %0h", c, bus.rdata_b, m_rd_b);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_read();
    test_raw();
    test_burst();
    test_drop();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
